fp_div_iter: RTL and testbench

- Iterative divider for the 24-bit GPU float format: 1 sign bit, 8 exponent bits (bias 127) and 15 mantissa bits with an implicit leading 1.
- It is the inverse-direction companion of the FP multiplier's normalise/pack stage. It unpacks two operands, runs restoring mantissa division one quotient bit per cycle, then normalises and packs using the same zero/overflow conventions as the multiplier.
- It sits beside the multiplier in the shader FP unit and uses a valid/ready handshake on both sides.

---
 rtl/fp_div_iter.sv | 161 ++++++++++++++++
 tb/tb_fp_div_iter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Iterative restoring divider for the 24-bit GPU float (1/8/15, bias 127).
// One quotient bit per cycle, then a single normalise/pack cycle; valid/ready on both sides.
module fp_div_iter #(
  parameter int WIDTH = 24,
  parameter int QBITS = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int MAN_W = 15;
  localparam int EXP_W = 8;
  localparam int CNT_W = $clog2(QBITS);
  localparam logic [WIDTH-1:0] INF_RES  = WIDTH'(24'h7f8000);
  localparam logic [WIDTH-1:0] NAN_RES  = WIDTH'(24'h7fc000);
  localparam logic [WIDTH-1:0] ZERO_RES = '0;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     sign_q, sign_d;
  logic signed [9:0]        e_q, e_d;
  logic [QBITS-1:0]         r_q, r_d;
  logic [QBITS-1:0]         q_q, q_d;
  logic [QBITS-2:0]         d_q, d_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]         result_q, result_d;

  logic [EXP_W-1:0]         a_exp, b_exp;
  logic                     a_zero, b_zero;
  logic                     qbit;
  logic [QBITS-2:0]         diff;
  logic signed [9:0]        exp_n;
  logic [MAN_W-1:0]         man_n;

  // Underflow flushes to +0 and overflow saturates to +inf, both with sign dropped.
  function automatic logic [WIDTH-1:0] sat_pack(input logic sgn,
                                                 input logic signed [9:0] ex,
                                                 input logic [MAN_W-1:0] man);
    if (ex <= 10'sd0)
      return ZERO_RES;
    else if (ex >= 10'sd255)
      return INF_RES;
    else
      return {sgn, ex[EXP_W-1:0], man};
  endfunction

  assign a_exp  = a_i[WIDTH-2 -: EXP_W];
  assign b_exp  = b_i[WIDTH-2 -: EXP_W];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);

  // r stays below 2*d, so the low bits of the difference are exact whenever r >= d.
  assign qbit = (r_q >= {1'b0, d_q});
  assign diff = r_q[QBITS-2:0] - d_q;

  assign man_n = q_q[QBITS-1] ? q_q[MAN_W:1] : q_q[MAN_W-1:0];
  assign exp_n = q_q[QBITS-1] ? e_q : e_q - 10'sd1;

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    sign_d   = sign_q;
    e_d      = e_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          sign_d  = a_i[WIDTH-1] ^ b_i[WIDTH-1];
          if (a_zero || b_zero) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = b_zero ? (a_zero ? NAN_RES : INF_RES) : ZERO_RES;
          end else begin
            state_d = DIV;
            e_d     = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
            r_d     = {1'b0, 1'b1, a_i[MAN_W-1:0]};
            d_d     = {1'b1, b_i[MAN_W-1:0]};
            q_d     = '0;
            cnt_d   = CNT_W'(QBITS - 1);
          end
        end
      end
      DIV: begin
        r_d = qbit ? {diff, 1'b0} : {r_q[QBITS-2:0], 1'b0};
        q_d = {q_q[QBITS-2:0], qbit};
        if (cnt_q == '0)
          state_d = NORM;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      NORM: begin
        result_d = sat_pack(sign_q, exp_n, man_n);
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sign_q   <= 1'b0;
      e_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      sign_q   <= sign_d;
      e_q      <= e_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: directed cases, handshake/reset scenarios and
// random operands checked against an integer-arithmetic reference model.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [23:0] a_i = '0;
  logic [23:0] b_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [23:0] result_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int transfers = 0;
  int rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high
  logic [23:0] exp_q[$];

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] r;
    int          lat;
  } dir_t;
  dir_t dir_tab[10];

  fp_div_iter #(.WIDTH(24), .QBITS(17)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Real-number view: quotient of the 1.15 mantissas scaled by 2^16, floored.
  function automatic logic [23:0] model(input logic [23:0] a, input logic [23:0] b);
    int     ae;
    int     be;
    int     e;
    longint num;
    longint den;
    longint q;
    longint m;
    logic [7:0]  e8;
    logic [14:0] m15;
    ae = int'(a[22:15]);
    be = int'(b[22:15]);
    if (be == 0) return (ae == 0) ? 24'h7fc000 : 24'h7f8000;
    if (ae == 0) return 24'h000000;
    num = (longint'(32768) + longint'(a[14:0])) * 65536;
    den = longint'(32768) + longint'(b[14:0]);
    q   = num / den;
    e   = ae - be + 127;
    if (q >= 65536) begin
      m = (q / 2) % 32768;
    end else begin
      m = q % 32768;
      e = e - 1;
    end
    if (e <= 0) return 24'h000000;
    if (e >= 255) return 24'h7f8000;
    e8  = 8'(e);
    m15 = 15'(m);
    return {a[23] ^ b[23], e8, m15};
  endfunction

  function automatic logic [23:0] rand_fp();
    int         sel;
    logic [7:0] ex;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       ex = 8'd0;
      1:       ex = 8'd255;
      2:       ex = 8'($urandom_range(1, 20));
      3:       ex = 8'($urandom_range(235, 254));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), ex, 15'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Present operands, wait for the accept edge, then record the expected result.
  task automatic issue(input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] want, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    a_i = a;
    b_i = b;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) begin
      chk("accept_timeout", 32'(n), 32'd0);
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(want);
      accepts++;
    end
    valid_i = keep;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ready_o !== 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: drives ready_i and scores every transfer against the queue.
  initial begin
    logic [23:0] want;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       ready_i = 1'($urandom_range(0, 1));
        1:       ready_i = 1'b0;
        default: ready_i = 1'b1;
      endcase
      if (!rst && valid_o === 1'b1 && ready_i) begin
        transfers++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(result_o), 32'hffffffff);
        end else begin
          want = exp_q.pop_front();
          chk("result", 32'(result_o), 32'(want));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;
    logic [23:0] ra;
    logic [23:0] rb;

    dir_tab[0] = '{24'h3f8000, 24'h3f8000, 24'h3f8000, 19};
    dir_tab[1] = '{24'h40c000, 24'h400000, 24'h404000, 19};
    dir_tab[2] = '{24'hc0c000, 24'h400000, 24'hc04000, 19};
    dir_tab[3] = '{24'h3f8000, 24'h404000, 24'h3eaaaa, 19};
    dir_tab[4] = '{24'h3f8000, 24'h000000, 24'h7f8000, 1};
    dir_tab[5] = '{24'h000000, 24'h000000, 24'h7fc000, 1};
    dir_tab[6] = '{24'h000000, 24'h404000, 24'h000000, 1};
    dir_tab[7] = '{24'h7f0000, 24'h008000, 24'h7f8000, 19};
    dir_tab[8] = '{24'h008000, 24'h7f0000, 24'h000000, 19};
    dir_tab[9] = '{24'h001234, 24'h004321, 24'h7fc000, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_result", 32'(result_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;

    rdy_mode = 2;
    foreach (dir_tab[i]) begin
      issue(dir_tab[i].a, dir_tab[i].b, dir_tab[i].r, 1'b0);
      n = 1;
      @(negedge clk);
      while (valid_o !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("latency", 32'(n), 32'(dir_tab[i].lat));
      drain();
    end

    // Consumer stalls for 10 cycles: output must hold.
    rdy_mode = 1;
    issue(24'h40c000, 24'h400000, 24'h404000, 1'b0);
    n = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_ready", 32'(ready_o), 32'd0);
      chk("stall_result", 32'(result_o), 32'h404000);
      @(negedge clk);
    end
    rdy_mode = 2;
    drain();

    // Reset in the middle of DIV discards the operation.
    issue(24'h3f8000, 24'h404000, 24'h3eaaaa, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("div_busy", 32'(busy_o), 32'd1);
    chk("div_ready", 32'(ready_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    void'(exp_q.pop_back());
    accepts--;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (valid_o === 1'b1) seen++;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);

    // Random operands with a randomly stalling consumer.
    rdy_mode = 0;
    for (int k = 0; k < 60; k++) begin
      ra = rand_fp();
      rb = rand_fp();
      issue(ra, rb, model(ra, rb), 1'b0);
    end
    drain();

    // valid_i never drops: one accept per transfer.
    for (int k = 0; k < 40; k++) begin
      ra = rand_fp();
      rb = rand_fp();
      issue(ra, rb, model(ra, rb), 1'b1);
    end
    valid_i = 1'b0;
    rdy_mode = 2;
    drain();
    repeat (3) @(negedge clk);
    chk("accept_vs_transfer", 32'(transfers), 32'(accepts));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
